dpcm_sat_scheduler: RTL and testbench

DPCM_SAT_SCHEDULER -- requirements
Module: dpcm_sat_scheduler

---
 rtl/dpcm_pkg.sv | 16 +
 rtl/sat_clamp.sv | 25 ++
 rtl/dpcm_sat_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dpcm_sat_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpcm_pkg.sv
// Shared definitions for the DPCM saturation scheduler: FSM encoding,
// default sample width and the reset values of the clamp thresholds.
package dpcm_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] SAT_UPPER_DEF = 8'h78;  // +120
  localparam logic [7:0] SAT_LOWER_DEF = 8'hF8;  // -8

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLAMP = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_clamp.sv
// Signed clamp of one sample against an upper/lower threshold pair.
// A sample equal to a threshold passes through unclamped.
module sat_clamp #(
  parameter int W = dpcm_pkg::DATA_W
) (
  input  logic [W-1:0] sample,
  input  logic [W-1:0] upper,
  input  logic [W-1:0] lower,
  output logic [W-1:0] result,
  output logic         sat
);

  always_comb begin
    result = sample;
    sat    = 1'b0;
    if ($signed(sample) > $signed(upper)) begin
      result = upper;
      sat    = 1'b1;
    end else if ($signed(sample) < $signed(lower)) begin
      result = lower;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dpcm_sat_scheduler.sv
// Round-robin arbiter feeding one shared signed clamp engine.
// IDLE grants and captures, CLAMP registers the result, OUT holds it until taken.
module dpcm_sat_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = dpcm_pkg::DATA_W,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_sat,
  input  logic                      cfg_we,
  input  logic                      cfg_sel,
  input  logic [DATA_W-1:0]         cfg_data,
  output logic                      cfg_err,
  output logic [15:0]               sat_count,
  output logic                      busy
);

  import dpcm_pkg::*;

  // Handshakes: a requester transfers when req_valid[i] && req_ready[i] on a
  // rising edge; the response transfers when resp_valid && resp_ready.
  // Valid may not depend on ready, and payload holds while valid && !ready.

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   upper_q, upper_d;
  logic [DATA_W-1:0]   lower_q, lower_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic                resp_sat_q, resp_sat_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                cfg_err_q, cfg_err_d;

  logic                grant_any;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                accept;
  logic [DATA_W-1:0]   clamp_result;
  logic                clamp_sat;
  logic [DATA_W-1:0]   new_upper, new_lower;
  int                  idx;

  // Upward search from ptr with wrap; the first asserted valid wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[ID_W'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (grant_any) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready  = (state_q == ST_IDLE && !reset) ? grant_oh : '0;
  assign accept     = |(req_valid & req_ready);
  assign resp_valid = (state_q == ST_OUT) && !reset;
  assign busy       = (state_q != ST_IDLE) && !reset;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_sat   = resp_sat_q;
  assign cfg_err    = cfg_err_q;
  assign sat_count  = cnt_q;

  sat_clamp #(.W(DATA_W)) u_clamp (
    .sample (sample_q),
    .upper  (upper_q),
    .lower  (lower_q),
    .result (clamp_result),
    .sat    (clamp_sat)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    sample_d    = sample_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_sat_d  = resp_sat_q;
    cnt_d       = cnt_q;
    upper_d     = upper_q;
    lower_d     = lower_q;
    cfg_err_d   = 1'b0;
    new_upper   = cfg_sel ? upper_q : cfg_data;
    new_lower   = cfg_sel ? cfg_data : lower_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_CLAMP;
          sample_d = req_data[int'(grant_id)*DATA_W +: DATA_W];
          id_d     = grant_id;
          ptr_d    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
      end
      ST_CLAMP: begin
        state_d     = ST_OUT;
        resp_data_d = clamp_result;
        resp_id_d   = id_q;
        resp_sat_d  = clamp_sat;
        if (clamp_sat && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      ST_OUT: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Thresholds only change while idle with no accept, and must stay ordered.
    if (cfg_we) begin
      if (state_q != ST_IDLE || accept || $signed(new_upper) < $signed(new_lower)) begin
        cfg_err_d = 1'b1;
      end else begin
        upper_d = new_upper;
        lower_d = new_lower;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      sample_q    <= '0;
      upper_q     <= DATA_W'($signed(SAT_UPPER_DEF));
      lower_q     <= DATA_W'($signed(SAT_LOWER_DEF));
      resp_data_q <= '0;
      resp_id_q   <= '0;
      resp_sat_q  <= 1'b0;
      cnt_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      sample_q    <= sample_d;
      upper_q     <= upper_d;
      lower_q     <= lower_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_sat_q  <= resp_sat_d;
      cnt_q       <= cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_dpcm_sat_scheduler.sv
// Bench for dpcm_sat_scheduler: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_dpcm_sat_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic           resp_sat;
  logic           cfg_we = 1'b0;
  logic           cfg_sel = 1'b0;
  logic [W-1:0]   cfg_data = '0;
  logic           cfg_err;
  logic [15:0]    sat_count;
  logic           busy;

  dpcm_sat_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_sat   (resp_sat),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .sat_count  (sat_count),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  bit         v_v[N];
  logic [7:0] v_d[N];
  bit         rr, we, sel, rst;
  logic [7:0] cd;

  // ---------------- reference model ----------------
  // phase: 0 waiting for a grant, 1 result being computed, 2 result offered
  int  m_phase, m_ptr, m_up, m_lo, m_cnt;
  bit  m_err, m_cur_sat;
  logic [10:0] exp_q[$];   // {sat, id, data}

  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_up = 120; m_lo = -8; m_cnt = 0; m_err = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) v_v[i] = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int w, s, r, nu, nl;
    bit sat;
    @(negedge clk);
    reset = rst; resp_ready = rr; cfg_we = we; cfg_sel = sel; cfg_data = cd;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = v_v[i];
      req_data[i*W +: W] = v_d[i];
    end
    #1;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      model_reset();
      return;
    end
    exp_rdy = '0;
    w = -1;
    if (m_phase == 0)
      for (int k = 0; k < N; k++)
        if (w < 0 && v_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk("sat_count", 32'(sat_count), 32'(m_cnt));
    if (m_phase == 2) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else chk("resp", 32'({resp_sat, resp_id, resp_data}), 32'(exp_q[0]));
    end

    m_err = 0;
    if (we) begin
      if (m_phase != 0 || w >= 0) m_err = 1;
      else begin
        nu = sel ? m_up : sx(cd);
        nl = sel ? sx(cd) : m_lo;
        if (nu < nl) m_err = 1;
        else begin m_up = nu; m_lo = nl; end
      end
    end
    case (m_phase)
      0: if (w >= 0) begin
        s = sx(v_d[w]);
        if (s > m_up)      begin r = m_up; sat = 1; end
        else if (s < m_lo) begin r = m_lo; sat = 1; end
        else               begin r = s;    sat = 0; end
        exp_q.push_back({sat, 2'(w), 8'(r)});
        m_cur_sat = sat;
        m_ptr = (w + 1) % N;
        m_phase = 1;
        v_v[w] = 0;
      end
      1: begin
        if (m_cur_sat && m_cnt < 65535) m_cnt++;
        m_phase = 2;
      end
      default: if (rr) begin
        void'(exp_q.pop_front());
        m_phase = 0;
      end
    endcase
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'(m_up);
      1: return 8'(m_lo);
      2: return 8'(m_up + 1);
      3: return 8'(m_lo - 1);
      4: return $urandom_range(0, 1) ? 8'h7F : 8'h80;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    rr = 0; we = 0; sel = 0; rst = 1; cd = '0;
    for (int i = 0; i < N; i++) begin v_v[i] = 0; v_d[i] = '0; end
    model_reset();

    repeat (3) step();
    rst = 0;
    @(posedge clk); #1;
    chk("reset_resp_data", 32'(resp_data), 32'd0);
    chk("reset_resp_id", 32'(resp_id), 32'd0);
    chk("reset_resp_sat", 32'(resp_sat), 32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
    chk("reset_sat_count", 32'(sat_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // single request, latency through the model phases
    rr = 1;
    v_v[0] = 1; v_d[0] = 8'h10;
    repeat (4) step();

    // clamp both ways and the equality boundary
    v_v[0] = 1; v_d[0] = 8'h7F; repeat (3) step();
    v_v[0] = 1; v_d[0] = 8'h80; repeat (3) step();
    v_v[0] = 1; v_d[0] = 8'h78; repeat (3) step();
    step();
    chk("sat_count_after_clamps", 32'(sat_count), 32'd2);

    // round robin from ptr=0 with everyone requesting
    rst = 1; step(); rst = 0;
    for (int i = 0; i < N; i++) v_d[i] = 8'($urandom_range(0, 255));
    repeat (15) begin
      for (int i = 0; i < N; i++) v_v[i] = 1;
      step();
    end
    for (int i = 0; i < N; i++) v_v[i] = 0;
    repeat (3) step();

    // backpressure while offering a result
    v_v[2] = 1; v_d[2] = 8'h05;
    step(); step();
    rr = 0; v_v[1] = 1; v_d[1] = 8'h33;
    repeat (5) step();
    rr = 1;
    repeat (6) step();

    // threshold writes: accepted, illegal order, while busy, coinciding with accept
    we = 1; sel = 0; cd = 8'h40; step(); we = 0;
    v_v[0] = 1; v_d[0] = 8'h50; repeat (4) step();
    we = 1; sel = 1; cd = 8'h50; step(); we = 0; step();
    v_v[1] = 1; v_d[1] = 8'h20; step();
    we = 1; sel = 0; cd = 8'h30; step(); we = 0;
    repeat (3) step();
    v_v[3] = 1; v_d[3] = 8'h60; we = 1; sel = 1; cd = 8'h00; step(); we = 0;
    repeat (4) step();

    // reset while a sample is in CLAMP
    v_v[0] = 1; v_d[0] = 8'h7F; step();
    rst = 1; step(); rst = 0;
    repeat (3) step();
    v_v[0] = 1; v_d[0] = 8'h50; repeat (4) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!v_v[i] && $urandom_range(0, 3) == 0) begin v_v[i] = 1; v_d[i] = pick(); end
      rr  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 9) == 0);
      sel = 1'($urandom_range(0, 1));
      cd  = $urandom_range(0, 1) ? pick() : 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; we = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
